// File: rtl/vc_sync_fifo_if.sv
// Write/read handshake, control and status bundle for vc_sync_fifo.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface vc_sync_fifo_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              wr_full;
    logic              almost_full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_empty;
    logic              almost_empty;
    logic [ADDR_W:0]   water_level;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, clr_err, wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_valid, rd_empty,
               almost_empty, water_level, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_valid, rd_empty,
               almost_empty, water_level, overflow, underflow
    );
endinterface

// File: rtl/vc_sync_fifo.sv
// Single-clock FIFO for the voice-change audio path.
// Standard or first-word-fall-through read mode, optional output register,
// programmable almost-full/almost-empty thresholds, flush and sticky
// overflow/underflow flags. Pointers carry one extra MSB so that full and
// empty are distinct when the addresses are equal.
module vc_sync_fifo #(
    parameter int DATA_W           = 16,
    parameter int ADDR_W           = 11,
    parameter int ALMOST_FULL_NUM  = 2040,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int FWFT             = 0,
    parameter int OUTPUT_REG       = 0
) (
    input  logic           clk,
    input  logic           rst,
    vc_sync_fifo_if.slave  bus
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_AF    = (ADDR_W + 1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_W:0] LVL_AE    = (ADDR_W + 1)'(ALMOST_EMPTY_NUM);
    localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W + 1)'(1);
    localparam bit              IS_FWFT   = (FWFT != 0);
    localparam bit              USE_OREG  = (FWFT == 0) && (OUTPUT_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   level;
    logic [DATA_W-1:0] ram_q;      // synchronous read port / FWFT head word
    logic              stage_v;    // ram_q holds a freshly read (std) or head (FWFT) word
    logic [DATA_W-1:0] oreg_q;
    logic              oreg_v;
    logic              overflow_q;
    logic              underflow_q;

    logic wr_full;
    logic rd_empty;
    logic wr_ok;
    logic rd_ok;
    logic wr_rej;
    logic rd_rej;
    logic fetch_en;

    // Status and handshake decode; flush masks every request in its cycle.
    assign wr_full  = (level == LVL_FULL);
    assign rd_empty = IS_FWFT ? ~stage_v : (level == '0);
    assign wr_ok    = bus.wr_en & ~wr_full  & ~bus.flush;
    assign rd_ok    = bus.rd_en & ~rd_empty & ~bus.flush;
    assign wr_rej   = bus.wr_en &  wr_full  & ~bus.flush;
    assign rd_rej   = bus.rd_en &  rd_empty & ~bus.flush;

    // Standard mode reads the RAM on every accepted read. FWFT prefetches the
    // next word whenever the RAM holds one beyond the head word and the
    // output stage is free or being popped this cycle, so pops have no bubble.
    assign fetch_en = IS_FWFT
                    ? ((level != {{ADDR_W{1'b0}}, stage_v}) & (~stage_v | rd_ok) & ~bus.flush)
                    : rd_ok;

    // Storage write port.
    // NOTE: the storage array is deliberately not reset so it maps onto block
    // RAM; pointers and level define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    // Synchronous read port; holds its value between reads and across flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q <= '0;
        end else if (fetch_en) begin
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    // Pointers and water level.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + LVL_ONE;
            end
            if (fetch_en) begin
                rd_ptr <= rd_ptr + LVL_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Read-stage valid: one-cycle pulse in standard mode, head-word valid in FWFT.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            stage_v <= 1'b0;
        end else if (IS_FWFT) begin
            stage_v <= fetch_en | (stage_v & ~rd_ok);
        end else begin
            stage_v <= rd_ok;
        end
    end

    // Optional second output stage for standard mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_q <= '0;
            oreg_v <= 1'b0;
        end else if (bus.flush) begin
            oreg_v <= 1'b0;
        end else begin
            oreg_v <= stage_v;
            if (stage_v) begin
                oreg_q <= ram_q;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_rej) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (rd_rej) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.wr_full      = wr_full;
    assign bus.rd_empty     = rd_empty;
    assign bus.almost_full  = (level >= LVL_AF);
    assign bus.almost_empty = (level <= LVL_AE);
    assign bus.water_level  = level;
    assign bus.rd_data      = USE_OREG ? oreg_q : ram_q;
    assign bus.rd_valid     = USE_OREG ? oreg_v : stage_v;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_vc_sync_fifo.sv
// Directed self-checking bench for vc_sync_fifo: three instances cover
// standard, FWFT and standard-with-output-register modes.
module tb_vc_sync_fifo;

    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vc_sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) if_std  ();
    vc_sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) if_fwft ();
    vc_sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) if_oreg ();

    vc_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2),
                   .FWFT(0), .OUTPUT_REG(0))
        u_std (.clk(clk), .rst(tb_rst), .bus(if_std));

    vc_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2),
                   .FWFT(1), .OUTPUT_REG(0))
        u_fwft (.clk(clk), .rst(tb_rst), .bus(if_fwft));

    vc_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2),
                   .FWFT(0), .OUTPUT_REG(1))
        u_oreg (.clk(clk), .rst(tb_rst), .bus(if_oreg));

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_std(input logic [DW-1:0] d);
        if_std.wr_en   = 1'b1;
        if_std.wr_data = d;
        tick();
        if_std.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        tb_rst = 1'b1;
        tick();
        tick();
        tb_rst = 1'b0;
        vectors++; if (if_std.wr_full !== 1'b0)      begin miscompares++; $display("FAIL reset_wr_full got=%0b exp=0", if_std.wr_full); end
        vectors++; if (if_std.almost_full !== 1'b0)  begin miscompares++; $display("FAIL reset_almost_full got=%0b exp=0", if_std.almost_full); end
        vectors++; if (if_std.rd_empty !== 1'b1)     begin miscompares++; $display("FAIL reset_rd_empty got=%0b exp=1", if_std.rd_empty); end
        vectors++; if (if_std.almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_almost_empty got=%0b exp=1", if_std.almost_empty); end
        vectors++; if (if_std.water_level !== 5'd0)  begin miscompares++; $display("FAIL reset_level got=%0d exp=0", if_std.water_level); end
        vectors++; if (if_std.rd_data !== 16'h0)     begin miscompares++; $display("FAIL reset_rd_data got=%h exp=0000", if_std.rd_data); end
        vectors++; if (if_std.rd_valid !== 1'b0)     begin miscompares++; $display("FAIL reset_rd_valid got=%0b exp=0", if_std.rd_valid); end
        vectors++; if (if_std.overflow !== 1'b0)     begin miscompares++; $display("FAIL reset_overflow got=%0b exp=0", if_std.overflow); end
        vectors++; if (if_std.underflow !== 1'b0)    begin miscompares++; $display("FAIL reset_underflow got=%0b exp=0", if_std.underflow); end
        vectors++; if (if_fwft.rd_valid !== 1'b0)    begin miscompares++; $display("FAIL reset_fwft_valid got=%0b exp=0", if_fwft.rd_valid); end
        vectors++; if (if_fwft.rd_empty !== 1'b1)    begin miscompares++; $display("FAIL reset_fwft_empty got=%0b exp=1", if_fwft.rd_empty); end
        vectors++; if (if_oreg.rd_data !== 16'h0)    begin miscompares++; $display("FAIL reset_oreg_data got=%h exp=0000", if_oreg.rd_data); end
    endtask

    task automatic test_fill_drain();
        logic            exp_b;
        logic [DW-1:0]   exp_d;
        for (int i = 0; i < 16; i++) begin
            push_std(16'hFFFF - 16'(i));
            vectors++; if (if_std.water_level !== 5'(i + 1)) begin miscompares++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, if_std.water_level, i + 1); end
            exp_b = (i + 1 >= 14);
            vectors++; if (if_std.almost_full !== exp_b) begin miscompares++; $display("FAIL fill_almost_full[%0d] got=%0b exp=%0b", i, if_std.almost_full, exp_b); end
            exp_b = (i == 15);
            vectors++; if (if_std.wr_full !== exp_b) begin miscompares++; $display("FAIL fill_wr_full[%0d] got=%0b exp=%0b", i, if_std.wr_full, exp_b); end
        end
        for (int i = 0; i < 16; i++) begin
            exp_d = 16'hFFFF - 16'(i);
            if_std.rd_en = 1'b1;
            tick();
            if_std.rd_en = 1'b0;
            vectors++; if (if_std.rd_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, if_std.rd_valid); end
            vectors++; if (if_std.rd_data !== exp_d) begin miscompares++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, if_std.rd_data, exp_d); end
            exp_b = (15 - i <= 2);
            vectors++; if (if_std.almost_empty !== exp_b) begin miscompares++; $display("FAIL drain_almost_empty[%0d] got=%0b exp=%0b", i, if_std.almost_empty, exp_b); end
            tick();
            vectors++; if (if_std.rd_valid !== 1'b0) begin miscompares++; $display("FAIL drain_pulse[%0d] got=%0b exp=0", i, if_std.rd_valid); end
            vectors++; if (if_std.rd_data !== exp_d) begin miscompares++; $display("FAIL drain_hold[%0d] got=%h exp=%h", i, if_std.rd_data, exp_d); end
        end
        vectors++; if (if_std.rd_empty !== 1'b1)    begin miscompares++; $display("FAIL drain_empty got=%0b exp=1", if_std.rd_empty); end
        vectors++; if (if_std.water_level !== 5'd0) begin miscompares++; $display("FAIL drain_level got=%0d exp=0", if_std.water_level); end
    endtask

    task automatic test_overflow_underflow();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 16; i++) push_std(16'h0100 + 16'(i));
        push_std(16'hDEAD);
        vectors++; if (if_std.overflow !== 1'b1)     begin miscompares++; $display("FAIL ovf_set got=%0b exp=1", if_std.overflow); end
        vectors++; if (if_std.water_level !== 5'd16) begin miscompares++; $display("FAIL ovf_level got=%0d exp=16", if_std.water_level); end
        if_std.clr_err = 1'b1;
        tick();
        if_std.clr_err = 1'b0;
        vectors++; if (if_std.overflow !== 1'b0)     begin miscompares++; $display("FAIL ovf_clear got=%0b exp=0", if_std.overflow); end
        // Full with read and write together: read wins, write is rejected.
        if_std.wr_en = 1'b1; if_std.wr_data = 16'hBEEF; if_std.rd_en = 1'b1;
        tick();
        if_std.wr_en = 1'b0; if_std.rd_en = 1'b0;
        vectors++; if (if_std.overflow !== 1'b1)     begin miscompares++; $display("FAIL full_rw_ovf got=%0b exp=1", if_std.overflow); end
        vectors++; if (if_std.water_level !== 5'd15) begin miscompares++; $display("FAIL full_rw_level got=%0d exp=15", if_std.water_level); end
        vectors++; if (if_std.rd_data !== 16'h0100)  begin miscompares++; $display("FAIL full_rw_data got=%h exp=0100", if_std.rd_data); end
        for (int i = 1; i < 16; i++) begin
            exp_d = 16'h0100 + 16'(i);
            if_std.rd_en = 1'b1;
            tick();
            if_std.rd_en = 1'b0;
            vectors++; if (if_std.rd_data !== exp_d) begin miscompares++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, if_std.rd_data, exp_d); end
        end
        tick();
        if_std.rd_en = 1'b1;
        tick();
        if_std.rd_en = 1'b0;
        vectors++; if (if_std.underflow !== 1'b1) begin miscompares++; $display("FAIL udf_set got=%0b exp=1", if_std.underflow); end
        vectors++; if (if_std.rd_valid !== 1'b0)  begin miscompares++; $display("FAIL udf_valid got=%0b exp=0", if_std.rd_valid); end
        // New error in the same cycle as clr_err keeps the flag set.
        if_std.rd_en = 1'b1; if_std.clr_err = 1'b1;
        tick();
        if_std.rd_en = 1'b0;
        vectors++; if (if_std.underflow !== 1'b1) begin miscompares++; $display("FAIL udf_set_wins got=%0b exp=1", if_std.underflow); end
        tick();
        if_std.clr_err = 1'b0;
        vectors++; if (if_std.underflow !== 1'b0) begin miscompares++; $display("FAIL udf_clear got=%0b exp=0", if_std.underflow); end
        vectors++; if (if_std.overflow !== 1'b0)  begin miscompares++; $display("FAIL ovf_clear2 got=%0b exp=0", if_std.overflow); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 8; i++) push_std(16'h2000 + 16'(i));
        for (int c = 0; c < 40; c++) begin
            exp_d = 16'h2000 + 16'(c);
            if_std.wr_en = 1'b1; if_std.wr_data = 16'h2008 + 16'(c); if_std.rd_en = 1'b1;
            tick();
            vectors++; if (if_std.water_level !== 5'd8) begin miscompares++; $display("FAIL b2b_level[%0d] got=%0d exp=8", c, if_std.water_level); end
            vectors++; if (if_std.rd_valid !== 1'b1)    begin miscompares++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", c, if_std.rd_valid); end
            vectors++; if (if_std.rd_data !== exp_d)    begin miscompares++; $display("FAIL b2b_data[%0d] got=%h exp=%h", c, if_std.rd_data, exp_d); end
        end
        if_std.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_d = 16'h2028 + 16'(i);
            tick();
            vectors++; if (if_std.rd_data !== exp_d) begin miscompares++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", i, if_std.rd_data, exp_d); end
        end
        if_std.rd_en = 1'b0;
        tick();
        vectors++; if (if_std.rd_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty got=%0b exp=1", if_std.rd_empty); end
    endtask

    task automatic test_fwft();
        logic [DW-1:0] exp_d;
        if_fwft.wr_en = 1'b1; if_fwft.wr_data = 16'h1234;
        tick();
        if_fwft.wr_en = 1'b0;
        vectors++; if (if_fwft.rd_valid !== 1'b0)    begin miscompares++; $display("FAIL fwft_early got=%0b exp=0", if_fwft.rd_valid); end
        vectors++; if (if_fwft.water_level !== 5'd1) begin miscompares++; $display("FAIL fwft_level got=%0d exp=1", if_fwft.water_level); end
        tick();
        vectors++; if (if_fwft.rd_valid !== 1'b1)    begin miscompares++; $display("FAIL fwft_valid got=%0b exp=1", if_fwft.rd_valid); end
        vectors++; if (if_fwft.rd_data !== 16'h1234) begin miscompares++; $display("FAIL fwft_data got=%h exp=1234", if_fwft.rd_data); end
        vectors++; if (if_fwft.rd_empty !== 1'b0)    begin miscompares++; $display("FAIL fwft_empty got=%0b exp=0", if_fwft.rd_empty); end
        if_fwft.rd_en = 1'b1;
        tick();
        if_fwft.rd_en = 1'b0;
        vectors++; if (if_fwft.rd_valid !== 1'b0)    begin miscompares++; $display("FAIL fwft_pop got=%0b exp=0", if_fwft.rd_valid); end
        vectors++; if (if_fwft.water_level !== 5'd0) begin miscompares++; $display("FAIL fwft_pop_level got=%0d exp=0", if_fwft.water_level); end
        for (int i = 0; i < 4; i++) begin
            if_fwft.wr_en = 1'b1; if_fwft.wr_data = 16'h00A0 + 16'(i);
            tick();
        end
        if_fwft.wr_en = 1'b0;
        if_fwft.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 16'h00A0 + 16'(i);
            vectors++; if (if_fwft.rd_valid !== 1'b1) begin miscompares++; $display("FAIL fwft_b2b_valid[%0d] got=%0b exp=1", i, if_fwft.rd_valid); end
            vectors++; if (if_fwft.rd_data !== exp_d) begin miscompares++; $display("FAIL fwft_b2b_data[%0d] got=%h exp=%h", i, if_fwft.rd_data, exp_d); end
            tick();
        end
        if_fwft.rd_en = 1'b0;
        vectors++; if (if_fwft.rd_valid !== 1'b0)    begin miscompares++; $display("FAIL fwft_done got=%0b exp=0", if_fwft.rd_valid); end
        vectors++; if (if_fwft.water_level !== 5'd0) begin miscompares++; $display("FAIL fwft_done_level got=%0d exp=0", if_fwft.water_level); end
        vectors++; if (if_fwft.underflow !== 1'b0)   begin miscompares++; $display("FAIL fwft_udf got=%0b exp=0", if_fwft.underflow); end
    endtask

    task automatic test_output_reg();
        if_oreg.wr_en = 1'b1; if_oreg.wr_data = 16'h55AA;
        tick();
        if_oreg.wr_data = 16'h66BB;
        tick();
        if_oreg.wr_en = 1'b0;
        tick();
        if_oreg.rd_en = 1'b1;
        tick();
        if_oreg.rd_en = 1'b0;
        vectors++; if (if_oreg.rd_valid !== 1'b0)    begin miscompares++; $display("FAIL oreg_n1 got=%0b exp=0", if_oreg.rd_valid); end
        tick();
        vectors++; if (if_oreg.rd_valid !== 1'b1)    begin miscompares++; $display("FAIL oreg_n2_valid got=%0b exp=1", if_oreg.rd_valid); end
        vectors++; if (if_oreg.rd_data !== 16'h55AA) begin miscompares++; $display("FAIL oreg_n2_data got=%h exp=55aa", if_oreg.rd_data); end
        tick();
        vectors++; if (if_oreg.rd_valid !== 1'b0)    begin miscompares++; $display("FAIL oreg_pulse got=%0b exp=0", if_oreg.rd_valid); end
        if_oreg.rd_en = 1'b1;
        tick();
        if_oreg.rd_en = 1'b0;
        vectors++; if (if_oreg.rd_data !== 16'h55AA) begin miscompares++; $display("FAIL oreg_hold got=%h exp=55aa", if_oreg.rd_data); end
        tick();
        vectors++; if (if_oreg.rd_valid !== 1'b1)    begin miscompares++; $display("FAIL oreg_2nd_valid got=%0b exp=1", if_oreg.rd_valid); end
        vectors++; if (if_oreg.rd_data !== 16'h66BB) begin miscompares++; $display("FAIL oreg_2nd_data got=%h exp=66bb", if_oreg.rd_data); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 16; i++) push_std(16'h3000 + 16'(i));
        push_std(16'hDEAD);
        for (int i = 0; i < 5; i++) begin
            if_std.rd_en = 1'b1;
            tick();
            if_std.rd_en = 1'b0;
            tick();
        end
        if_std.rd_en = 1'b1;
        tick();
        vectors++; if (if_std.water_level !== 5'd10) begin miscompares++; $display("FAIL flush_pre_level got=%0d exp=10", if_std.water_level); end
        vectors++; if (if_std.overflow !== 1'b1)     begin miscompares++; $display("FAIL flush_pre_ovf got=%0b exp=1", if_std.overflow); end
        if_std.flush = 1'b1; if_std.wr_en = 1'b1; if_std.wr_data = 16'h9999;
        tick();
        if_std.flush = 1'b0; if_std.wr_en = 1'b0; if_std.rd_en = 1'b0;
        vectors++; if (if_std.water_level !== 5'd0)  begin miscompares++; $display("FAIL flush_level got=%0d exp=0", if_std.water_level); end
        vectors++; if (if_std.rd_empty !== 1'b1)     begin miscompares++; $display("FAIL flush_empty got=%0b exp=1", if_std.rd_empty); end
        vectors++; if (if_std.overflow !== 1'b1)     begin miscompares++; $display("FAIL flush_ovf_kept got=%0b exp=1", if_std.overflow); end
        vectors++; if (if_std.rd_valid !== 1'b0)     begin miscompares++; $display("FAIL flush_valid got=%0b exp=0", if_std.rd_valid); end
        vectors++; if (if_std.rd_data !== 16'h3005)  begin miscompares++; $display("FAIL flush_data_kept got=%h exp=3005", if_std.rd_data); end
        vectors++; if (if_std.wr_full !== 1'b0)      begin miscompares++; $display("FAIL flush_full got=%0b exp=0", if_std.wr_full); end
        push_std(16'h4242);
        if_std.rd_en = 1'b1;
        tick();
        if_std.rd_en = 1'b0;
        vectors++; if (if_std.rd_valid !== 1'b1)     begin miscompares++; $display("FAIL flush_new_valid got=%0b exp=1", if_std.rd_valid); end
        vectors++; if (if_std.rd_data !== 16'h4242)  begin miscompares++; $display("FAIL flush_new_data got=%h exp=4242", if_std.rd_data); end
        vectors++; if (if_std.water_level !== 5'd0)  begin miscompares++; $display("FAIL flush_new_level got=%0d exp=0", if_std.water_level); end
        // Read request on an empty FIFO during flush must not raise underflow.
        if_std.flush = 1'b1; if_std.rd_en = 1'b1;
        tick();
        if_std.flush = 1'b0; if_std.rd_en = 1'b0;
        vectors++; if (if_std.underflow !== 1'b0)    begin miscompares++; $display("FAIL flush_no_udf got=%0b exp=0", if_std.underflow); end
    endtask

    initial begin
        if_std.flush  = 1'b0; if_std.clr_err  = 1'b0; if_std.wr_en  = 1'b0; if_std.rd_en  = 1'b0; if_std.wr_data  = '0;
        if_fwft.flush = 1'b0; if_fwft.clr_err = 1'b0; if_fwft.wr_en = 1'b0; if_fwft.rd_en = 1'b0; if_fwft.wr_data = '0;
        if_oreg.flush = 1'b0; if_oreg.clr_err = 1'b0; if_oreg.wr_en = 1'b0; if_oreg.rd_en = 1'b0; if_oreg.wr_data = '0;
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_back_to_back();
        test_fwft();
        test_output_reg();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vc_sync_fifo.md
Name: vc_sync_fifo

Overview:
Single-clock, parametrised FIFO for the voice-change audio path; next generation of the vendor-IP async FIFO used there. Adds programmable thresholds, standard or first-word-fall-through (FWFT) read mode, optional output register, flush, and sticky overflow/underflow flags. Sits between the sample capture stage and the pitch/voice-change processing core, which share one clock domain.

Parameters:
DATA_W, 16, data word width (1..1152).
ADDR_W, 11, address width; depth DEPTH = 2**ADDR_W (4..20).
ALMOST_FULL_NUM, 2040, almost_full asserts when level >= this value.
ALMOST_EMPTY_NUM, 4, almost_empty asserts when level <= this value.
FWFT, 0, 1 = first-word-fall-through read mode.
OUTPUT_REG, 0, 1 = extra output register stage; standard mode only, ignored when FWFT=1.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
flush  in  1  synchronous clear of contents; takes effect the cycle it is sampled.
clr_err  in  1  clears the overflow and underflow sticky flags.
wr_data  in  DATA_W  write data.
wr_en  in  1  write request.
wr_full  out  1  FIFO full.
almost_full  out  1  level >= ALMOST_FULL_NUM.
rd_en  in  1  read request (standard mode) or acknowledge (FWFT).
rd_data  out  DATA_W  read data.
rd_valid  out  1  rd_data holds a valid word.
rd_empty  out  1  no word available to read.
almost_empty  out  1  level <= ALMOST_EMPTY_NUM.
water_level  out  ADDR_W+1  words held, 0..DEPTH.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: wr_full 0, almost_full 0, rd_empty 1, almost_empty 1, water_level 0, rd_data 0, rd_valid 0, overflow 0, underflow 0. Pointers are cleared.
- Storage: DEPTH x DATA_W RAM with a synchronous read port. Write and read pointers are ADDR_W+1 bits wide. The extra MSB distinguishes full from empty across the wrap.
- Write acceptance: wr_ok = wr_en & ~wr_full. A rejected write sets overflow and leaves contents and pointers unchanged.
- Read acceptance: rd_ok = rd_en & ~rd_empty. A rejected read sets underflow, leaves state unchanged and does not assert rd_valid.
- Simultaneous wr_ok and rd_ok: level unchanged and both pointers advance.
- When full and wr_en & rd_en occur in the same cycle, the read is accepted and the write is rejected, which sets overflow.
- Standard mode, OUTPUT_REG=0: rd_data and rd_valid (one-cycle pulse) are updated 1 cycle after rd_ok. rd_data holds its value between reads.
- Standard mode, OUTPUT_REG=1: same, with 2 cycles latency.
- FWFT mode: the head word is prefetched into the output stage. rd_valid = ~rd_empty, and rd_data shows the head word while rd_valid=1. rd_en with rd_valid=1 pops the word, and the next word is visible the following cycle with no bubble. Latency from a write into an empty FIFO to rd_valid is 2 cycles.
- water_level counts words written and not yet popped, including any prefetched FWFT word. It is registered and updated the cycle after the event.
- wr_full = (water_level == DEPTH). rd_empty = (water_level == 0) in standard mode.
- almost_full and almost_empty are derived from the registered water_level, so they change in the same cycle as water_level.
- Flush: pointers, level, the FWFT output stage and rd_valid are cleared next edge, giving the reset values except that overflow, underflow and rd_data are retained. wr_en and rd_en in the flush cycle are ignored and do not set the sticky flags.
- Priority: rst > flush > normal operation. For the sticky flags, a set in the same cycle as clr_err wins.
- Pointer wrap: at DEPTH-1 the address wraps to 0 and the MSB toggles. Data order is preserved across any number of wraps.

Test Plan:
(Bench uses DATA_W=16, ADDR_W=4, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2.)
- Fill and drain, standard mode: write 16 words 0xFFFF downward. Required: wr_full=1 and water_level=16 after the 16th write; almost_full=1 from level 14. Then read 16. Required: data 0xFFFF..0xFFF0 in order, rd_valid 1 cycle after each rd_en, rd_empty=1 at the end.
- Overflow and underflow: write a 17th word while full. Required: overflow=1 and the data unchanged. Read while empty. Required: underflow=1 and no rd_valid. clr_err pulse: both flags return to 0.
- Simultaneous read and write at level 8, repeated for 40 cycles (wraps pointers twice). Required: water_level stays 8 and the data sequence is unbroken.
- FWFT: single write of 0x1234 into an empty FIFO. Required: rd_valid=1 with rd_data=0x1234 two cycles later. Back-to-back pops of 4 words yield 4 consecutive words with no gap.
- OUTPUT_REG=1: rd_en at cycle N gives rd_valid and data at N+2.
- Flush at level 10 with overflow=1. Required next cycle: water_level=0, rd_empty=1, overflow still 1. A new write-then-read returns the new data.
